// File: rtl/yonga_lz4_ingress_pkg.sv
// Shared encodings for the LZ4 block ingress: FSM states, error codes and header geometry.
package yonga_lz4_ingress_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_HDR2    = 3'd3,
    ST_HDR3    = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERSIZE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_UNCOMP   = 2'd3;

  localparam int HDR_BYTES = 4;

  // States in which a stalled upstream counts toward the timeout.
  function automatic logic timer_active(input state_t s);
    return (s == ST_HDR1) || (s == ST_HDR2) || (s == ST_HDR3) || (s == ST_PAYLOAD);
  endfunction

endpackage

// File: rtl/yonga_stall_timer.sv
// Idle-cycle watchdog: counts cycles while run is high and clr is low, flags expiry.
module yonga_stall_timer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Fires in the cycle whose update would bring the count to TIMEOUT_CYCLES-1,
  // so the owner reacts on the same edge the count gets there.
  assign expired = run && !clr && (cnt_q == TO_W'(TIMEOUT_CYCLES - 2));

  always_comb begin
    cnt_d = cnt_q + TO_W'(1);
    if (clr || !run) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/yonga_lz4_block_ingress.sv
// Parses LZ4 block-size headers from the UART rx FIFO and forwards each block's payload
// to the decoder compressed-data FIFO, with block accounting, end-mark and error reporting.
module yonga_lz4_block_ingress
  import yonga_lz4_ingress_pkg::*;
#(
  parameter int LEN_W           = 23,
  parameter int MAX_BLOCK_BYTES = 4194304,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int TO_W            = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_err,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  output logic        comp_wr_en,
  output logic [7:0]  comp_wr_data,
  input  logic        comp_fifo_full,
  output logic        busy,
  output logic        frame_done,
  output logic        block_done,
  output logic [15:0] blocks_count,
  output logic        err,
  output logic [1:0]  err_code
);

  state_t                     state_q;
  logic [8*HDR_BYTES-9:0]     hdr_q;
  logic [LEN_W-1:0]           rem_q;
  logic                       comp_wr_en_q;
  logic [7:0]                 comp_wr_data_q;
  logic                       busy_q;
  logic                       frame_done_q;
  logic                       block_done_q;
  logic [15:0]                blocks_q;
  logic                       err_q;
  logic [1:0]                 err_code_q;

  logic [8*HDR_BYTES-1:0]     hdr_word;
  logic                       to_expired;
  logic [1:0]                 fault_d;

  assign hdr_word = {rx_data, hdr_q};

  always_comb begin
    rx_rd = 1'b0;
    case (state_q)
      ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3: rx_rd = !rx_empty;
      // Never pop while a write is in flight, so the full flag seen is always current.
      ST_PAYLOAD: rx_rd = !rx_empty && !comp_fifo_full && !comp_wr_en_q;
      default:    rx_rd = 1'b0;
    endcase
  end

  yonga_stall_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_rd),
    .run     (timer_active(state_q)),
    .expired (to_expired)
  );

  always_comb begin
    fault_d = ERR_NONE;
    if (to_expired) begin
      fault_d = ERR_TIMEOUT;
    end else if (state_q == ST_HDR3 && rx_rd && hdr_word != '0) begin
      if (hdr_word[31])                                 fault_d = ERR_UNCOMP;
      else if (hdr_word[30:0] > 31'(MAX_BLOCK_BYTES))   fault_d = ERR_OVERSIZE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hdr_q          <= '0;
      rem_q          <= '0;
      comp_wr_en_q   <= 1'b0;
      comp_wr_data_q <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      block_done_q   <= 1'b0;
      blocks_q       <= '0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      comp_wr_en_q <= 1'b0;
      frame_done_q <= 1'b0;
      block_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (enable) begin
          state_q  <= ST_HDR0;
          blocks_q <= '0;
          busy_q   <= 1'b1;
        end
        ST_HDR0: if (rx_rd) begin hdr_q[7:0]   <= rx_data; state_q <= ST_HDR1; end
        ST_HDR1: if (rx_rd) begin hdr_q[15:8]  <= rx_data; state_q <= ST_HDR2; end
        ST_HDR2: if (rx_rd) begin hdr_q[23:16] <= rx_data; state_q <= ST_HDR3; end
        ST_HDR3: if (rx_rd) begin
          if (hdr_word == '0) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (fault_d == ERR_NONE) begin
            rem_q   <= hdr_word[LEN_W-1:0];
            state_q <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: if (rx_rd) begin
          comp_wr_en_q   <= 1'b1;
          comp_wr_data_q <= rx_data;
          rem_q          <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            block_done_q <= 1'b1;
            blocks_q     <= blocks_q + 16'd1;
            state_q      <= ST_HDR0;
          end
        end
        ST_ERR: if (clear_err) begin
          err_q      <= 1'b0;
          err_code_q <= ERR_NONE;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (fault_d != ERR_NONE) begin
        err_q      <= 1'b1;
        err_code_q <= fault_d;
        busy_q     <= 1'b0;
        state_q    <= ST_ERR;
      end
    end
  end

  assign comp_wr_en   = comp_wr_en_q;
  assign comp_wr_data = comp_wr_data_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign block_done   = block_done_q;
  assign blocks_count = blocks_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_yonga_lz4_block_ingress.sv
// Directed bench for the LZ4 block ingress: a byte-array model of the UART rx FIFO feeds the DUT.
module tb_yonga_lz4_block_ingress;

  logic        clk = 1'b0;
  logic        rst, enable, clear_err, comp_fifo_full;
  logic        rx_empty, rx_rd, comp_wr_en, busy, frame_done, block_done, err;
  logic [7:0]  rx_data, comp_wr_data;
  logic [15:0] blocks_count;
  logic [1:0]  err_code;

  logic [7:0]  mem    [0:255];
  logic [7:0]  wr_log [0:255];
  int wr_ptr = 0, rd_ptr = 0, n_wr = 0, n_bd = 0, n_fd = 0, cyc = 0, pop_edge = 0;
  logic pop_pend = 1'b0;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign rx_empty = (rd_ptr == wr_ptr);
  assign rx_data  = mem[rd_ptr[7:0]];

  yonga_lz4_block_ingress #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
    .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .comp_wr_en(comp_wr_en), .comp_wr_data(comp_wr_data), .comp_fifo_full(comp_fifo_full),
    .busy(busy), .frame_done(frame_done), .block_done(block_done),
    .blocks_count(blocks_count), .err(err), .err_code(err_code)
  );

  always @(posedge clk) begin
    pop_pend <= rx_rd && !rst;
    if (rx_rd && !rst) pop_edge <= cyc + 1;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (pop_pend) rd_ptr++;
    if (comp_wr_en) begin wr_log[n_wr[7:0]] = comp_wr_data; n_wr++; end
    if (block_done) n_bd++;
    if (frame_done) n_fd++;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b; wr_ptr++;
  endtask

  task automatic start_frame();
    enable = 1'b1; tick(); enable = 1'b0;
  endtask

  // which: 0 bytes written, 1 block_done pulses, 2 frame_done pulses, 3 err flag
  task automatic wait_for(input int which, input int target, input int limit, input string tag);
    int v; bit hit;
    v = 0; hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      case (which)
        0: v = n_wr;
        1: v = n_bd;
        2: v = n_fd;
        default: v = int'(err);
      endcase
      if (v >= target) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL %s: timed out after %0d cycles, got %0d required %0d", tag, limit, v, target); end
  endtask

  task automatic end_frame(input string tag);
    int fd0;
    fd0 = n_fd;
    repeat (4) push(8'h00);
    wait_for(2, fd0 + 1, 100, tag);
  endtask

  task automatic clear_error();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clear_err = 1'b0; comp_fifo_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if (rx_rd !== 1'b0)        begin n_fail++; $display("FAIL rst_rx_rd: got %b required 0", rx_rd); end
    n_checks++; if (comp_wr_en !== 1'b0)   begin n_fail++; $display("FAIL rst_wr_en: got %b required 0", comp_wr_en); end
    n_checks++; if (comp_wr_data !== 8'h0) begin n_fail++; $display("FAIL rst_wr_data: got %h required 00", comp_wr_data); end
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (frame_done !== 1'b0 || block_done !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got %b%b required 00", frame_done, block_done); end
    n_checks++; if (blocks_count !== 16'h0) begin n_fail++; $display("FAIL rst_blocks: got %0d required 0", blocks_count); end
    n_checks++; if (err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL rst_err: got %b/%0d required 0/0", err, err_code); end
  endtask

  task automatic test_basic_block();
    logic [7:0] exp [5];
    int b0, bd0;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    b0 = n_wr; bd0 = n_bd;
    push(8'h05); push(8'h00); push(8'h00); push(8'h00);
    foreach (exp[i]) push(exp[i]);
    start_frame();
    wait_for(1, bd0 + 1, 100, "basic_block_done");
    n_checks++; if (n_wr - b0 !== 5) begin n_fail++; $display("FAIL basic_count: got %0d required 5", n_wr - b0); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (wr_log[(b0 + i) % 256] !== exp[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h required %h", i, wr_log[(b0 + i) % 256], exp[i]); end
    end
    n_checks++; if (blocks_count !== 16'd1) begin n_fail++; $display("FAIL basic_blocks: got %0d required 1", blocks_count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hdr0: got %b required 1", busy); end
    tick();
    n_checks++; if (n_bd - bd0 !== 1 || block_done !== 1'b0) begin n_fail++; $display("FAIL basic_bd_pulse: got %0d pulses level %b required 1/0", n_bd - bd0, block_done); end
    end_frame("basic_end");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [5];
    int b0, bd0, r0;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    b0 = n_wr; bd0 = n_bd;
    push(8'h05); push(8'h00); push(8'h00); push(8'h00);
    foreach (exp[i]) push(exp[i]);
    start_frame();
    wait_for(0, b0 + 2, 100, "stall_two_bytes");
    comp_fifo_full = 1'b1;
    r0 = rd_ptr;
    repeat (25) tick();
    clear_error();
    repeat (24) tick();
    n_checks++; if (rd_ptr !== r0) begin n_fail++; $display("FAIL stall_no_pop: got %0d pops required 0", rd_ptr - r0); end
    n_checks++; if (n_wr - b0 !== 2) begin n_fail++; $display("FAIL stall_writes: got %0d required 2", n_wr - b0); end
    n_checks++; if (busy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL stall_state: busy/err %b/%b required 1/0", busy, err); end
    comp_fifo_full = 1'b0;
    wait_for(1, bd0 + 1, 100, "stall_block_done");
    n_checks++; if (n_wr - b0 !== 5) begin n_fail++; $display("FAIL stall_count: got %0d required 5", n_wr - b0); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (wr_log[(b0 + i) % 256] !== exp[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h required %h", i, wr_log[(b0 + i) % 256], exp[i]); end
    end
    n_checks++; if (blocks_count !== 16'd1) begin n_fail++; $display("FAIL stall_blocks: got %0d required 1", blocks_count); end
    end_frame("stall_end");
  endtask

  task automatic test_end_mark();
    int b0, bd0, fd0;
    b0 = n_wr; bd0 = n_bd; fd0 = n_fd;
    push(8'h03); push(8'h00); push(8'h00); push(8'h00);
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (4) push(8'h00);
    start_frame();
    wait_for(2, fd0 + 1, 200, "endmark_frame_done");
    n_checks++; if (n_wr - b0 !== 3 || wr_log[b0 % 256] !== 8'hAA || wr_log[(b0 + 2) % 256] !== 8'hCC) begin n_fail++; $display("FAIL endmark_data: got %0d bytes first %h last %h required 3 AA CC", n_wr - b0, wr_log[b0 % 256], wr_log[(b0 + 2) % 256]); end
    n_checks++; if (n_bd - bd0 !== 1) begin n_fail++; $display("FAIL endmark_bd: got %0d required 1", n_bd - bd0); end
    n_checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL endmark_idle: frame_done/busy %b/%b required 1/0", frame_done, busy); end
    n_checks++; if (blocks_count !== 16'd1) begin n_fail++; $display("FAIL endmark_blocks: got %0d required 1", blocks_count); end
    tick();
    n_checks++; if (frame_done !== 1'b0 || busy !== 1'b0 || rx_rd !== 1'b0) begin n_fail++; $display("FAIL endmark_after: fd/busy/rd %b/%b/%b required 0/0/0", frame_done, busy, rx_rd); end
  endtask

  task automatic test_header_errors();
    int r0;
    push(8'h00); push(8'h00); push(8'h00); push(8'h80); push(8'h99);
    start_frame();
    wait_for(3, 1, 50, "uncomp_err");
    n_checks++; if (err_code !== 2'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL uncomp_code: code/busy %0d/%b required 3/0", err_code, busy); end
    r0 = rd_ptr;
    repeat (5) tick();
    n_checks++; if (rx_rd !== 1'b0 || rd_ptr !== r0 || err !== 1'b1) begin n_fail++; $display("FAIL uncomp_hold: rd/pops/err %b/%0d/%b required 0/0/1", rx_rd, rd_ptr - r0, err); end
    clear_error();
    n_checks++; if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL uncomp_clear: err/code/busy %b/%0d/%b required 0/0/0", err, err_code, busy); end
    wr_ptr = rd_ptr;
    push(8'h01); push(8'h00); push(8'h40); push(8'h00);
    start_frame();
    wait_for(3, 1, 50, "oversize_err");
    n_checks++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL oversize_code: got %0d required 1", err_code); end
    clear_error();
    n_checks++; if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL oversize_clear: err/busy %b/%b required 0/0", err, busy); end
  endtask

  task automatic test_timeout();
    int b0;
    b0 = n_wr;
    push(8'h0A); push(8'h00); push(8'h00); push(8'h00);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    start_frame();
    wait_for(3, 1, 400, "timeout_err");
    n_checks++; if (err_code !== 2'd2) begin n_fail++; $display("FAIL timeout_code: got %0d required 2", err_code); end
    n_checks++; if (cyc - pop_edge !== 99) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles required 99", cyc - pop_edge); end
    n_checks++; if (n_wr - b0 !== 4) begin n_fail++; $display("FAIL timeout_writes: got %0d required 4", n_wr - b0); end
    clear_error();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b required 0", err); end
  endtask

  task automatic test_reset_mid_payload();
    int b0, b1;
    b0 = n_wr;
    push(8'h08); push(8'h00); push(8'h00); push(8'h00);
    push(8'hA1); push(8'hA2); push(8'hA3);
    start_frame();
    wait_for(0, b0 + 2, 100, "rstpl_two_bytes");
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (comp_wr_en !== 1'b0 || n_wr - b0 !== 2) begin n_fail++; $display("FAIL rstpl_drop: wr_en/bytes %b/%0d required 0/2", comp_wr_en, n_wr - b0); end
    n_checks++; if (busy !== 1'b0 || rx_rd !== 1'b0 || blocks_count !== 16'd0 || comp_wr_data !== 8'h00) begin n_fail++; $display("FAIL rstpl_state: busy/rd/blocks/data %b/%b/%0d/%h required 0/0/0/00", busy, rx_rd, blocks_count, comp_wr_data); end
    rst = 1'b0;
    tick();
    wr_ptr = rd_ptr;
    b1 = n_wr;
    push(8'h02); push(8'h00); push(8'h00); push(8'h00); push(8'h5A); push(8'hA5);
    start_frame();
    end_frame("rstpl_clean_end");
    n_checks++; if (n_wr - b1 !== 2 || wr_log[b1 % 256] !== 8'h5A || wr_log[(b1 + 1) % 256] !== 8'hA5) begin n_fail++; $display("FAIL rstpl_clean_data: got %0d bytes %h %h required 2 5A A5", n_wr - b1, wr_log[b1 % 256], wr_log[(b1 + 1) % 256]); end
    n_checks++; if (blocks_count !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstpl_clean_state: blocks/busy %0d/%b required 1/0", blocks_count, busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic_block();
    test_backpressure();
    test_end_mark();
    test_header_errors();
    test_timeout();
    test_reset_mid_payload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
